leaf_port_rr_arbiter: RTL and testbench
=======================================

// Module: leaf_port_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one leaf_interface user input port among NUM_REQ
//   HLS operator output streams (AXI-stream style TDATA/TVALID/TREADY).
//   Sits between the user operators of a page and din_leaf_user2interface/vld/ack.
//   Grants one requester at a time in bursts of up to BURST_MAX beats, then rotates.
//   The registered output stage breaks the combinational path between operator and interface.
// PARAMETERS
//   NUM_REQ      4   number of requesting streams, 2..8
//   DATA_W       32  payload width, matches PAYLOAD_BITS of leaf_interface
//   BURST_MAX    16  max beats per grant before forced rotation, 1..256
//   ID_W         2   grant index width, = clog2(NUM_REQ)
// PORTS
//   ap_clk        in   1               clock; all logic rising-edge
//   ap_rst_n      in   1               synchronous reset, active low
//   req_tdata     in   NUM_REQ*DATA_W  requester payloads; slice i = [i*DATA_W +: DATA_W]
//   req_tvalid    in   NUM_REQ         requester valid
//   req_tready    out  NUM_REQ         requester ready, one-hot or zero
//   dout_data     out  DATA_W          to din_leaf_user2interface
//   dout_vld      out  1               to vld_user2interface
//   dout_ack      in   1               from ack_interface2user
//   grant_id      out  ID_W            index of the current/last granted requester
//   grant_active  out  1               high while in the GRANT state
// BEHAVIOUR
//   Transfer rules: input beat i moves on req_tvalid[i] & req_tready[i].
//   Output beat moves on dout_vld & dout_ack.
//   Output register (obuf) has one entry; dout_vld = obuf_full.
//   obuf_can_load = !obuf_full | dout_ack.
//   req_tready[i] = (state==GRANT) & (grant_id==i) & obuf_can_load. Combinational in dout_ack.
//   Latency: an accepted input beat appears on dout_data/dout_vld the next cycle.
//   dout_data stays stable while dout_vld & !dout_ack.
//   obuf_full: set on load. Cleared on output transfer without a same-cycle load.
//   A same-cycle load and output transfer keeps obuf_full=1 with the new data.
//   FSM states:
//     IDLE:  req_tready=0. If |req_tvalid, choose the first i with req_tvalid[i],
//            searching from ptr+1 upward with wrap modulo NUM_REQ.
//            Load grant_id=i, burst_cnt=0, go to GRANT. Otherwise stay in IDLE.
//     GRANT: on each accepted beat, burst_cnt increments.
//            -> IDLE and ptr<=grant_id when the beat with burst_cnt==BURST_MAX-1 is accepted.
//            -> IDLE and ptr<=grant_id when req_tvalid[grant_id]==0 while obuf_can_load.
//            Otherwise stay in GRANT. If obuf is stalled, the grant is held and no rotation occurs.
//   Arbitration costs one bubble cycle per grant change: the IDLE cycle.
//   burst_cnt is clog2(BURST_MAX+1) bits wide and never wraps; it resets to 0 on each new grant.
//   ptr wraps NUM_REQ-1 -> 0. All index arithmetic is done modulo NUM_REQ.
//   Simultaneous requests are resolved by rotating priority only; there are no fixed priorities.
//   Data is not reordered within a requester. Requester streams are interleaved only at grant boundaries.
//   Reset values (ap_rst_n==0 at a clock edge):
//     state=IDLE, obuf_full=0, dout_vld=0, dout_data=0,
//     grant_id=0, grant_active=0, burst_cnt=0, ptr=NUM_REQ-1 (so the first grant goes to 0 when all request).
//   Reset mid-operation: any beat held in obuf is discarded. Requester-side beats not yet accepted stay with the requester.
//   Reset dominates all other events in the same cycle.
// TESTING
//   1. Reset, then only req0 valid with data 0xA0..0xA3 -> grant_id=0 after 1 cycle; dout 0xA0..0xA3 in consecutive cycles; dout_ack=1 throughout.
//   2. All 4 valid continuously, BURST_MAX=4, ack=1 -> bursts 0,1,2,3,0 of 4 beats each, one bubble between bursts.
//   3. req1 streaming, dout_ack held low 5 cycles -> dout_vld=1 with stable dout_data; req_tready=0; burst_cnt frozen; no lost or duplicated beats after ack.
//   4. req2 drops tvalid mid-burst after 2 beats while req3 valid -> IDLE, next grant goes to req3; ptr=2.
//   5. Wrap: ptr=3, req0 and req2 valid -> req0 granted first, then req2.
//   6. Assert ap_rst_n=0 while obuf_full=1 in GRANT -> next cycle dout_vld=0, req_tready=0, state IDLE; after release, first grant goes to the lowest valid index.
//   Scoreboard: per-requester in-order beat check; checks that req_tready is never multi-hot.

Source files
------------

// File: rtl/leaf_port_rr_arbiter_if.sv
// Bundle of signals between the HLS operator streams, the round-robin arbiter and
// the leaf_interface user input port. The debug fields expose the arbiter FSM.
`timescale 1ns/1ps
interface leaf_port_rr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int BC_W      = $clog2(BURST_MAX + 1)
);
  logic [NUM_REQ*DATA_W-1:0] req_tdata;
  logic [NUM_REQ-1:0]        req_tvalid;
  logic [NUM_REQ-1:0]        req_tready;
  logic [DATA_W-1:0]         dout_data;
  logic                      dout_vld;
  logic                      dout_ack;
  logic [ID_W-1:0]           grant_id;
  logic                      grant_active;
  logic                      dbg_state;      // 0 = IDLE, 1 = GRANT
  logic [ID_W-1:0]           dbg_ptr;
  logic [BC_W-1:0]           dbg_burst_cnt;

  // Operator / interface side: drives requests and the output acknowledge.
  modport master (
    output req_tdata, req_tvalid, dout_ack,
    input  req_tready, dout_data, dout_vld, grant_id, grant_active,
    input  dbg_state, dbg_ptr, dbg_burst_cnt
  );

  // Arbiter side.
  modport slave (
    input  req_tdata, req_tvalid, dout_ack,
    output req_tready, dout_data, dout_vld, grant_id, grant_active,
    output dbg_state, dbg_ptr, dbg_burst_cnt
  );
endinterface

// File: rtl/leaf_port_rr_arbiter.sv
// Round-robin arbiter sharing one leaf_interface user input port among NUM_REQ
// AXI-stream style operator outputs. One grant at a time, bursts of up to
// BURST_MAX beats, one IDLE bubble per grant change, one-entry output register.
//
// Handshake: an input beat i moves when req_tvalid[i] & req_tready[i] are both
// high at a rising edge; an output beat moves when dout_vld & dout_ack are both
// high at a rising edge. dout_data is held stable while dout_vld & !dout_ack.
// req_tready is combinational in dout_ack so a full obuf can drain and reload
// in the same cycle.
`timescale 1ns/1ps
module leaf_port_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input logic                 ap_clk,
  input logic                 ap_rst_n,
  leaf_port_rr_arbiter_if.slave bus
);
  localparam int BC_W = $clog2(BURST_MAX + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                obuf_full_q, obuf_full_d;
  logic [DATA_W-1:0]   obuf_data_q, obuf_data_d;
  logic                grant_active_q, grant_active_d;

  logic                obuf_can_load;
  logic                accept;
  logic                sel_valid;
  logic [DATA_W-1:0]   sel_data;
  logic                pick_found;
  logic [ID_W-1:0]     pick_id;
  logic [NUM_REQ-1:0]  tready;

  assign obuf_can_load = !obuf_full_q || bus.dout_ack;

  // Route the currently granted requester's valid and payload.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_W'(i)) begin
        sel_valid = bus.req_tvalid[i];
        sel_data  = bus.req_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Rotating-priority search: first valid requester after ptr, wrapping.
  always_comb begin : pick_search
    int idx;
    pick_found = 1'b0;
    pick_id    = ptr_q;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!pick_found && bus.req_tvalid[ID_W'(idx)]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  // Ready goes only to the granted requester, and only when obuf can take a beat.
  always_comb begin
    tready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tready[i] = (state_q == GRANT) && obuf_can_load && (grant_id_q == ID_W'(i));
    end
  end

  assign accept = (state_q == GRANT) && obuf_can_load && sel_valid;

  // Next-state logic for the grant FSM and the output register.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    obuf_full_d = obuf_full_q;
    obuf_data_d = obuf_data_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == BC_W'(BURST_MAX - 1)) begin
            state_d = IDLE;
            ptr_d   = grant_id_q;
          end
        end else if (obuf_can_load) begin
          // Granted requester has nothing to send: give up the grant.
          state_d = IDLE;
          ptr_d   = grant_id_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load wins over a same-cycle drain, keeping obuf full with new data.
    if (accept) begin
      obuf_full_d = 1'b1;
      obuf_data_d = sel_data;
    end else if (bus.dout_ack) begin
      obuf_full_d = 1'b0;
    end

    grant_active_d = (state_d == GRANT);
  end

  // State and output registers; reset discards any beat held in obuf.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      ptr_q          <= ID_W'(NUM_REQ - 1);
      burst_cnt_q    <= '0;
      obuf_full_q    <= 1'b0;
      obuf_data_q    <= '0;
      grant_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      ptr_q          <= ptr_d;
      burst_cnt_q    <= burst_cnt_d;
      obuf_full_q    <= obuf_full_d;
      obuf_data_q    <= obuf_data_d;
      grant_active_q <= grant_active_d;
    end
  end

  assign bus.req_tready    = tready;
  assign bus.dout_data     = obuf_data_q;
  assign bus.dout_vld      = obuf_full_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.grant_active  = grant_active_q;
  assign bus.dbg_state     = (state_q == GRANT);
  assign bus.dbg_ptr       = ptr_q;
  assign bus.dbg_burst_cnt = burst_cnt_q;
endmodule

// File: tb/tb_leaf_port_rr_arbiter.sv
// Bench for leaf_port_rr_arbiter: directed requester streams, expected output
// order pushed into a scoreboard queue, negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_leaf_port_rr_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 32;
  localparam int BURST_MAX = 4;
  localparam int ID_W      = 2;

  // ---------------- clock / reset ----------------
  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  leaf_port_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .ID_W(ID_W)) bus ();

  leaf_port_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .ID_W(ID_W)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                out_cyc[$];
  logic [DATA_W-1:0] src_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] en = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic note_fail(string name, string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic drive();
    logic [NUM_REQ-1:0]        tv;
    logic [NUM_REQ*DATA_W-1:0] td;
    tv = '0;
    td = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        tv[i] = 1'b1;
        td[i*DATA_W +: DATA_W] = src_q[i][0];
      end
    end
    bus.req_tvalid = tv;
    bus.req_tdata  = td;
  endtask

  // Requester model: a beat leaves its source queue only when accepted.
  initial begin : driver
    logic [NUM_REQ-1:0] take;
    forever begin
      @(negedge ap_clk);
      take = ap_rst_n ? (bus.req_tvalid & bus.req_tready) : '0;
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) if (take[i]) void'(src_q[i].pop_front());
      #1;
      drive();
    end
  end

  task automatic push_src(int r, logic [DATA_W-1:0] base, int n);
    for (int k = 0; k < n; k++) src_q[r].push_back(base + DATA_W'(k));
  endtask

  task automatic push_exp(logic [DATA_W-1:0] base, int n);
    for (int k = 0; k < n; k++) exp_q.push_back(base + DATA_W'(k));
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_drain(string name, int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !src_empty()) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) note_fail(name, $sformatf("not drained, %0d beats outstanding", exp_q.size()));
    repeat (3) tick();
  endtask

  task automatic wait_grant(string name, int id, int max);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!(bus.grant_active && bus.grant_id == ID_W'(id)) && n < max);
    if (n >= max) note_fail(name, $sformatf("grant to %0d never seen", id));
  endtask

  task automatic wait_active(string name, int max);
    int n;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!bus.grant_active && n < max);
    if (n >= max) note_fail(name, "grant_active never rose");
  endtask

  task automatic do_reset();
    tick();
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld", bus.dout_vld, 1);
        check("stall_data", bus.dout_data, prev_data);
      end
      if (bus.req_tready != '0) check("tready_onehot", $countones(bus.req_tready), 1);
      if (bus.dout_vld && bus.dout_ack) begin
        if (exp_q.size() == 0) begin
          note_fail("beat_data", $sformatf("got 0x%0h expected no beat", bus.dout_data));
        end else begin
          check("beat_data", bus.dout_data, exp_q.pop_front());
          out_cyc.push_back(cyc);
        end
      end
      prev_stall = bus.dout_vld && !bus.dout_ack;
      prev_data  = bus.dout_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.req_tvalid = '0;
    bus.req_tdata  = '0;
    bus.dout_ack   = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    // Reset values
    @(negedge ap_clk);
    check("rst_dout_vld", bus.dout_vld, 0);
    check("rst_dout_data", bus.dout_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_grant_active", bus.grant_active, 0);
    check("rst_tready", bus.req_tready, 0);
    check("rst_state", bus.dbg_state, 0);
    check("rst_ptr", bus.dbg_ptr, 3);
    check("rst_burst_cnt", bus.dbg_burst_cnt, 0);

    // 1: single requester, four beats back to back
    tick();
    out_cyc.delete();
    push_src(0, 32'hA0, 4);
    push_exp(32'hA0, 4);
    en = 4'b0001;
    tick();
    @(negedge ap_clk);
    check("t1_grant_id", bus.grant_id, 0);
    check("t1_grant_active", bus.grant_active, 1);
    check("t1_tready", bus.req_tready, 4'b0001);
    check("t1_dout_vld", bus.dout_vld, 0);
    wait_drain("t1_drain", 100);
    check("t1_out_count", out_cyc.size(), 4);
    for (int j = 1; j < out_cyc.size(); j++) check("t1_gap", out_cyc[j] - out_cyc[j-1], 1);
    check("t1_ptr", bus.dbg_ptr, 0);
    en = '0;

    // 2: all four requesting, bursts 0,1,2,3,0 with one bubble between
    do_reset();
    tick();
    out_cyc.delete();
    push_src(0, 32'h100, 8);
    push_src(1, 32'h110, 4);
    push_src(2, 32'h120, 4);
    push_src(3, 32'h130, 4);
    push_exp(32'h100, 4);
    push_exp(32'h110, 4);
    push_exp(32'h120, 4);
    push_exp(32'h130, 4);
    push_exp(32'h104, 4);
    en = 4'b1111;
    wait_drain("t2_drain", 300);
    check("t2_out_count", out_cyc.size(), 20);
    for (int j = 1; j < out_cyc.size(); j++)
      check($sformatf("t2_gap%0d", j), out_cyc[j] - out_cyc[j-1], (j % 4 == 0) ? 2 : 1);
    check("t2_ptr", bus.dbg_ptr, 0);
    en = '0;

    // 3: req1 streaming, output stalled for five cycles
    tick();
    push_src(1, 32'h200, 6);
    push_exp(32'h200, 6);
    en = 4'b0010;
    tick();
    tick();
    tick();
    bus.dout_ack = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge ap_clk);
      check("t3_vld", bus.dout_vld, 1);
      check("t3_data", bus.dout_data, 32'h201);
      check("t3_tready", bus.req_tready, 0);
      check("t3_burst_cnt", bus.dbg_burst_cnt, 2);
      check("t3_grant", bus.grant_active, 1);
    end
    tick();
    bus.dout_ack = 1'b1;
    wait_drain("t3_drain", 100);
    check("t3_ptr", bus.dbg_ptr, 1);
    en = '0;

    // 4: req2 runs dry after two beats, req3 waiting
    tick();
    push_src(2, 32'h300, 2);
    push_src(3, 32'h310, 3);
    push_exp(32'h300, 2);
    push_exp(32'h310, 3);
    en = 4'b1100;
    wait_grant("t4_grant3", 3, 50);
    check("t4_ptr", bus.dbg_ptr, 2);
    wait_drain("t4_drain", 100);
    en = '0;

    // 5: wrap from ptr=3 with req0 and req2 requesting
    @(negedge ap_clk);
    check("t5_ptr_before", bus.dbg_ptr, 3);
    tick();
    push_src(0, 32'h400, 2);
    push_src(2, 32'h420, 2);
    push_exp(32'h400, 2);
    push_exp(32'h420, 2);
    en = 4'b0101;
    tick();
    @(negedge ap_clk);
    check("t5_first_grant", bus.grant_id, 0);
    check("t5_first_active", bus.grant_active, 1);
    wait_drain("t5_drain", 100);
    en = '0;

    // 6: reset while obuf holds a beat in GRANT; held beat 0x500 is discarded
    tick();
    bus.dout_ack = 1'b0;
    push_src(1, 32'h500, 4);
    push_exp(32'h501, 3);
    en = 4'b0010;
    tick();
    tick();
    @(negedge ap_clk);
    check("t6_pre_vld", bus.dout_vld, 1);
    check("t6_pre_data", bus.dout_data, 32'h500);
    check("t6_pre_active", bus.grant_active, 1);
    tick();
    push_src(3, 32'h530, 2);
    push_exp(32'h530, 2);
    en = 4'b1010;
    ap_rst_n = 1'b0;
    tick();
    @(negedge ap_clk);
    check("t6_rst_vld", bus.dout_vld, 0);
    check("t6_rst_tready", bus.req_tready, 0);
    check("t6_rst_state", bus.dbg_state, 0);
    check("t6_rst_active", bus.grant_active, 0);
    check("t6_rst_ptr", bus.dbg_ptr, 3);
    tick();
    ap_rst_n = 1'b1;
    bus.dout_ack = 1'b1;
    wait_active("t6_regrant", 20);
    check("t6_first_grant", bus.grant_id, 1);
    wait_drain("t6_drain", 100);
    en = '0;

    // ---------------- final report ----------------
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    note_fail("watchdog", "simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule
